// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register of the 5-stage MIPS32 core.
//                Registers the decoded control bundle, register-file read
//                data, immediate, PC+4 and register fields for EX. Detects
//                load-use hazards against the instruction in EX and inserts a
//                single bubble, honours branch flush and downstream hold, and
//                keeps a saturating count of load-use bubbles.
//  Ports       : clk/rst          - clock, synchronous active-high reset
//                id_*             - decode-stage instruction bundle
//                flush            - kill the decode instruction (taken branch)
//                ex_hold          - freeze this stage (downstream stall)
//                ex_*             - registered bundle presented to EX
//                stall_if_id      - combinational hold request for PC, IF/ID
//                bubble_cnt       - saturating load-use bubble counter
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_RegDst,
    input  logic            id_Jump,
    input  logic            id_Branch,
    input  logic            id_Branchinv,
    input  logic            id_MemRead,
    input  logic            id_MemtoReg,
    input  logic            id_MemWrite,
    input  logic            id_ALUSrc,
    input  logic            id_RegWrite,
    input  logic [3:0]      id_ALUOp,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [4:0]      id_rd,
    input  logic [DW-1:0]   id_rdata1,
    input  logic [DW-1:0]   id_rdata2,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   id_pc4,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            ex_valid,
    output logic            ex_RegDst,
    output logic            ex_Jump,
    output logic            ex_Branch,
    output logic            ex_Branchinv,
    output logic            ex_MemRead,
    output logic            ex_MemtoReg,
    output logic            ex_MemWrite,
    output logic            ex_ALUSrc,
    output logic            ex_RegWrite,
    output logic [3:0]      ex_ALUOp,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_wreg,
    output logic [DW-1:0]   ex_rdata1,
    output logic [DW-1:0]   ex_rdata2,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc4,
    output logic            stall_if_id,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

    // Control bundle packed MSB..LSB:
    // RegDst, Jump, Branch, Branchinv, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite
    localparam int c_memread_bit = 4;

    logic            valid_q,  valid_d;
    logic [8:0]      ctrl_q,   ctrl_d;
    logic [3:0]      aluop_q,  aluop_d;
    logic [4:0]      rs_q,     rs_d;
    logic [4:0]      rt_q,     rt_d;
    logic [4:0]      rd_q,     rd_d;
    logic [4:0]      wreg_q,   wreg_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;
    logic [DW-1:0]   rdata2_q, rdata2_d;
    logic [DW-1:0]   imm_q,    imm_d;
    logic [DW-1:0]   pc4_q,    pc4_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;

    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_load_use;
    logic [8:0] w_id_ctrl;

    always_comb begin
        w_id_ctrl = {id_RegDst, id_Jump, id_Branch, id_Branchinv, id_MemRead,
                     id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite};

        // Which source registers the decode instruction actually reads.
        w_uses_rs = id_valid & ~id_Jump;
        w_uses_rt = id_valid & (id_RegDst | id_Branch | id_MemWrite);

        // $0 is hard-wired, so a load targeting it can never create a hazard.
        w_load_use = valid_q & ctrl_q[c_memread_bit] & (wreg_q != 5'd0) &
                     ((w_uses_rs & (id_rs == wreg_q)) |
                      (w_uses_rt & (id_rt == wreg_q)));

        stall_if_id = ~rst & (ex_hold | (w_load_use & ~flush));

        // Default: hold every register.
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        aluop_d  = aluop_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        wreg_d   = wreg_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        cnt_d    = cnt_q;

        if (!ex_hold) begin
            // Fields and data always load; a bubble is defined purely by
            // clearing valid and the control bundle.
            rs_d     = id_rs;
            rt_d     = id_rt;
            rd_d     = id_rd;
            wreg_d   = id_RegDst ? id_rd : id_rt;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            pc4_d    = id_pc4;
            if (flush || w_load_use) begin
                valid_d = 1'b0;
                ctrl_d  = 9'd0;
                aluop_d = 4'd0;
            end else begin
                valid_d = id_valid;
                ctrl_d  = w_id_ctrl;
                aluop_d = id_ALUOp;
            end
            // Only genuine load-use bubbles are counted; flush wins.
            if (w_load_use && !flush && (cnt_q != c_cnt_max)) begin
                cnt_d = cnt_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= 9'd0;
            aluop_q  <= 4'd0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            wreg_q   <= 5'd0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            aluop_q  <= aluop_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            wreg_q   <= wreg_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_RegDst    = ctrl_q[8];
    assign ex_Jump      = ctrl_q[7];
    assign ex_Branch    = ctrl_q[6];
    assign ex_Branchinv = ctrl_q[5];
    assign ex_MemRead   = ctrl_q[4];
    assign ex_MemtoReg  = ctrl_q[3];
    assign ex_MemWrite  = ctrl_q[2];
    assign ex_ALUSrc    = ctrl_q[1];
    assign ex_RegWrite  = ctrl_q[0];
    assign ex_ALUOp     = aluop_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_wreg      = wreg_q;
    assign ex_rdata1    = rdata1_q;
    assign ex_rdata2    = rdata2_q;
    assign ex_imm       = imm_q;
    assign ex_pc4       = pc4_q;
    assign bubble_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. A behavioural model of
//                the stage predicts the EX bundle after every edge; expected
//                bundles are queued and compared by an independent monitor.
//                The counter is narrowed so saturation is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DW   = 32;
    localparam int CNTW = 8;

    typedef struct packed {
        logic rst, flush, hold, valid;
        logic regdst, jump, branch, branchinv, memread, memtoreg, memwrite, alusrc, regwrite;
        logic [3:0] aluop;
        logic [4:0] rs, rt, rd;
        logic [DW-1:0] rd1, rd2, imm, pc4;
    } in_t;

    typedef struct packed {
        logic valid;
        logic [8:0] ctrl;
        logic [3:0] aluop;
        logic [4:0] rs, rt, rd, wreg;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [CNTW-1:0] cnt;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t cur = '0;

    logic            ex_valid, ex_RegDst, ex_Jump, ex_Branch, ex_Branchinv, ex_MemRead;
    logic            ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, stall_if_id;
    logic [3:0]      ex_ALUOp;
    logic [4:0]      ex_rs, ex_rt, ex_rd, ex_wreg;
    logic [DW-1:0]   ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [CNTW-1:0] bubble_cnt;

    id_ex_stage #(.DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(cur.rst), .id_valid(cur.valid),
        .id_RegDst(cur.regdst), .id_Jump(cur.jump), .id_Branch(cur.branch),
        .id_Branchinv(cur.branchinv), .id_MemRead(cur.memread), .id_MemtoReg(cur.memtoreg),
        .id_MemWrite(cur.memwrite), .id_ALUSrc(cur.alusrc), .id_RegWrite(cur.regwrite),
        .id_ALUOp(cur.aluop), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_rdata1(cur.rd1), .id_rdata2(cur.rd2), .id_imm(cur.imm), .id_pc4(cur.pc4),
        .flush(cur.flush), .ex_hold(cur.hold),
        .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_Jump(ex_Jump), .ex_Branch(ex_Branch),
        .ex_Branchinv(ex_Branchinv), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
        .ex_ALUOp(ex_ALUOp), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t exp_q[$];
    out_t m = '0;          // model of the EX bundle after the last edge
    logic last_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the stage must present after this edge.
    function automatic out_t model_next(input out_t s, input in_t x, output logic stall);
        out_t n;
        logic reads_rs, reads_rt, hazard;
        reads_rs = x.valid && !x.jump;
        reads_rt = x.valid && (x.regdst || x.branch || x.memwrite);
        hazard   = s.valid && s.ctrl[4] && (s.wreg != 0) &&
                   ((reads_rs && x.rs == s.wreg) || (reads_rt && x.rt == s.wreg));
        stall = !x.rst && (x.hold || (hazard && !x.flush));
        n = s;
        if (x.rst) begin
            n = '0;
        end else if (!x.hold) begin
            n.rs = x.rs; n.rt = x.rt; n.rd = x.rd;
            n.wreg = x.regdst ? x.rd : x.rt;
            n.rd1 = x.rd1; n.rd2 = x.rd2; n.imm = x.imm; n.pc4 = x.pc4;
            if (x.flush || hazard) begin
                n.valid = 0; n.ctrl = 0; n.aluop = 0;
                if (!x.flush && s.cnt < (2**CNTW - 1)) n.cnt = s.cnt + 1;
            end else begin
                n.valid = x.valid;
                n.ctrl  = {x.regdst, x.jump, x.branch, x.branchinv, x.memread,
                           x.memtoreg, x.memwrite, x.alusrc, x.regwrite};
                n.aluop = x.aluop;
            end
        end
        return n;
    endfunction

    // Drive one cycle: inputs after negedge, stall checked combinationally,
    // expected post-edge bundle queued for the monitor.
    task automatic step(input in_t x);
        logic st;
        out_t n;
        @(negedge clk);
        cur = x;
        #1;
        n = model_next(m, x, st);
        last_stall = stall_if_id;
        chk("stall_if_id", {63'd0, stall_if_id}, {63'd0, st});
        exp_q.push_back(n);
        m = n;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        out_t a, e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ex_valid, {ex_RegDst, ex_Jump, ex_Branch, ex_Branchinv, ex_MemRead,
                   ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite}, ex_ALUOp,
                   ex_rs, ex_rt, ex_rd, ex_wreg, ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
                   bubble_cnt};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ex_bundle: got %h expected %h", a, e);
            end
        end
    end

    function automatic in_t rnd_in();
        in_t x;
        logic [4:0] pick [4];
        x = '0;
        pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd4; pick[3] = 5'($urandom);
        x.valid    = ($urandom_range(0, 7) != 0);
        x.regdst   = 1'($urandom); x.jump = ($urandom_range(0, 5) == 0);
        x.branch   = ($urandom_range(0, 4) == 0); x.branchinv = 1'($urandom);
        x.memread  = ($urandom_range(0, 2) == 0); x.memtoreg = 1'($urandom);
        x.memwrite = ($urandom_range(0, 4) == 0); x.alusrc = 1'($urandom);
        x.regwrite = 1'($urandom); x.aluop = 4'($urandom);
        x.rs = pick[$urandom_range(0, 3)]; x.rt = pick[$urandom_range(0, 3)];
        x.rd = pick[$urandom_range(0, 3)];
        x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom; x.pc4 = $urandom;
        return x;
    endfunction

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic regdst, input logic memread, input logic jump);
        in_t x;
        x = '0;
        x.valid = 1; x.rs = rs; x.rt = rt; x.rd = rd; x.regdst = regdst;
        x.memread = memread; x.memtoreg = memread; x.jump = jump;
        x.regwrite = !jump; x.alusrc = memread;
        x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom; x.pc4 = $urandom;
        return x;
    endfunction

    initial begin
        in_t x;
        // Reset with random decode inputs.
        repeat (2) begin x = rnd_in(); x.rst = 1; x.hold = 1'($urandom); step(x); end
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_cnt", {56'd0, bubble_cnt}, 64'd0);

        // Pass-through R-type add.
        x = mk(5'd1, 5'd2, 5'd3, 1, 0, 0); x.rd1 = 5; x.rd2 = 7; step(x);
        chk("pass_valid", {63'd0, ex_valid}, 64'd1);
        chk("pass_wreg", {59'd0, ex_wreg}, 64'd3);
        chk("pass_rdata1", {32'd0, ex_rdata1}, 64'd5);
        chk("pass_rdata2", {32'd0, ex_rdata2}, 64'd7);
        chk("pass_stall", {63'd0, last_stall}, 64'd0);

        // Load-use: lw rt=8, then add rs=8 -> one bubble.
        step(mk(5'd1, 5'd8, 5'd0, 0, 1, 0));
        x = mk(5'd8, 5'd2, 5'd9, 1, 0, 0);
        step(x);
        chk("lu_stall", {63'd0, last_stall}, 64'd1);
        chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        chk("lu_bubble_regwrite", {63'd0, ex_RegWrite}, 64'd0);
        chk("lu_cnt", {56'd0, bubble_cnt}, 64'd1);
        step(x);
        chk("lu_release_stall", {63'd0, last_stall}, 64'd0);
        chk("lu_add_in_ex", {58'd0, ex_valid, ex_wreg}, {58'd0, 1'b1, 5'd9});

        // No false hazards.
        step(mk(5'd1, 5'd0, 5'd0, 0, 1, 0));
        step(mk(5'd0, 5'd2, 5'd3, 1, 0, 0));
        chk("nf_r0_stall", {63'd0, last_stall}, 64'd0);
        step(mk(5'd1, 5'd8, 5'd0, 0, 1, 0));
        step(mk(5'd8, 5'd8, 5'd0, 0, 0, 1));
        chk("nf_jump_stall", {63'd0, last_stall}, 64'd0);
        step(mk(5'd1, 5'd8, 5'd0, 0, 1, 0));
        step(mk(5'd4, 5'd8, 5'd0, 0, 0, 0));
        chk("nf_addi_stall", {63'd0, last_stall}, 64'd0);

        // Flush beats load-use.
        step(mk(5'd1, 5'd8, 5'd0, 0, 1, 0));
        x = mk(5'd8, 5'd2, 5'd9, 1, 0, 0); x.flush = 1; step(x);
        chk("fl_stall", {63'd0, last_stall}, 64'd0);
        chk("fl_valid", {63'd0, ex_valid}, 64'd0);
        chk("fl_cnt", {56'd0, bubble_cnt}, 64'd1);

        // Hold with flush and changing inputs: frozen.
        step(mk(5'd1, 5'd2, 5'd3, 1, 0, 0));
        repeat (3) begin
            x = rnd_in(); x.hold = 1; x.flush = 1; step(x);
            chk("hold_stall", {63'd0, last_stall}, 64'd1);
            chk("hold_frozen", {58'd0, ex_valid, ex_wreg}, {58'd0, 1'b1, 5'd3});
        end

        // Randomized traffic.
        repeat (600) begin
            x = rnd_in();
            x.hold  = ($urandom_range(0, 7) == 0);
            x.flush = ($urandom_range(0, 7) == 0);
            x.rst   = ($urandom_range(0, 99) == 0);
            step(x);
        end

        // Saturation: back-to-back dependent loads alternate capture/bubble.
        repeat (2 * (2**CNTW + 2) + 2) step(mk(5'd8, 5'd8, 5'd0, 0, 1, 0));
        chk("sat_cnt", {56'd0, bubble_cnt}, 64'hFF);
        step(mk(5'd8, 5'd8, 5'd0, 0, 1, 0));
        step(mk(5'd8, 5'd8, 5'd0, 0, 1, 0));
        chk("sat_hold", {56'd0, bubble_cnt}, 64'hFF);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS32 core; sits directly downstream of the decode control unit.
- Registers the decoded control bundle, register-file read data, immediate and register fields for the EX stage.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles. Handles branch flush and downstream hold.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width (read data, immediate, PC+4)
- CNTW, 16, width of the bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_RegDst, id_Jump, id_Branch, id_Branchinv, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoded control bits
- id_ALUOp  in  4  decoded ALU operation
- id_rs, id_rt, id_rd  in  5 each  instruction register fields
- id_rdata1, id_rdata2  in  DW each  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_pc4  in  DW  PC+4 of the decode instruction
- flush  in  1  branch/jump resolved taken; kill the decode instruction
- ex_hold  in  1  downstream stall; freeze this stage
- ex_valid  out  1  EX holds a real instruction
- ex_RegDst … ex_RegWrite, ex_ALUOp  out  same widths  registered control bundle
- ex_rs, ex_rt, ex_rd  out  5 each  registered fields
- ex_wreg  out  5  destination register = RegDst ? rd : rt, computed at capture
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DW each  registered data
- stall_if_id  out  1  combinational: hold PC and IF/ID this cycle
- bubble_cnt  out  CNTW  count of bubbles inserted by load-use detection

Behaviour:
- Reset, synchronous: all ex_* outputs = 0, including ex_valid and ex_wreg; bubble_cnt = 0. While rst is high, stall_if_id = 0.
- Latency: one cycle. id_* values sampled at edge N appear on ex_* after edge N.
- Decode use flags:
  - uses_rs = id_valid & ~id_Jump
  - uses_rt = id_valid & (id_RegDst | id_Branch | id_MemWrite)
- load_use = ex_valid & ex_MemRead & (ex_wreg != 0) & ((uses_rs & id_rs == ex_wreg) | (uses_rt & id_rt == ex_wreg))
- stall_if_id = ex_hold | (load_use & ~flush)
- Per-edge action, strict priority:
  1. rst: reset state.
  2. ex_hold: all ex_* registers keep their values. This applies even with flush high; upstream must hold flush until hold drops.
  3. flush: capture a bubble.
  4. load_use: capture a bubble; bubble_cnt += 1, saturating at all-ones.
  5. Otherwise: capture all id_* fields; ex_valid = id_valid.
- Bubble: ex_valid and every control bit = 0, ex_ALUOp = 0. Data and field registers still load from id_*, so a bubble has no architectural effect.
- If id_valid = 0 on a normal capture, control bits are captured as given. They are qualified by ex_valid = 0, so there is no architectural effect.
- Register $0 is never a hazard source.
- A load followed by a dependent instruction gives exactly one bubble. After the bubble, ex_valid = 0, so load_use drops and the dependent instruction is captured on the next edge.
- Flush takes priority over load_use: no bubble is counted and stall_if_id is not asserted from load_use.
- Counter does not wrap; it holds at 2^CNTW-1.

Test Plan:
- Reset: drive rst for 2 cycles with random id_* -> all ex_* = 0, bubble_cnt = 0, stall_if_id = 0.
- Pass-through: R-type add, rs=1, rt=2, rd=3, RegDst=1, RegWrite=1, ALUOp=0x0, rdata1=5, rdata2=7 -> next cycle ex_valid=1, ex_wreg=3, ex_rdata1=5, ex_rdata2=7, stall_if_id=0.
- Load-use: lw rt=8 (MemRead=1) captured, then decode add rs=8 -> stall_if_id=1 for one cycle; EX gets bubble (ex_valid=0, ex_RegWrite=0); bubble_cnt=1; add reaches EX on the following edge.
- No false hazards: lw rt=0 followed by add rs=0 -> no stall. lw rt=8 followed by jump -> no stall. lw rt=8 followed by addi writing rt=8 but rs=4 -> no stall.
- Flush vs hazard: load_use condition with flush=1 in the same cycle -> bubble inserted, stall_if_id=0, bubble_cnt unchanged.
- Hold: ex_hold=1 for 3 cycles with changing id_* and flush=1 -> ex_* frozen, stall_if_id=1 each cycle. Then force 2^CNTW+2 load-use events -> bubble_cnt saturates at 0xFFFF.
